// File: rtl/bus_ctrl_pkg.sv
// Shared types and default region map for the bus control unit.
// Optional feature macro used across the slice: UNMAPPED_ERR_EN.
package bus_ctrl_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_CS = 4;
  localparam int DEF_WAIT_W = 4;

  // Region struct fields are wide enough for any practical bus; users truncate.
  localparam int REGION_FIELD_W      = 32;
  localparam int REGION_WAIT_FIELD_W = 8;

  localparam logic [DEF_NUM_CS*DEF_ADDR_W-1:0] DEF_REGION_BASE =
    {20'h01C00, 20'h0FF00, 20'h80000, 20'h00000};
  localparam logic [DEF_NUM_CS*DEF_ADDR_W-1:0] DEF_REGION_MASK =
    {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000};
  localparam logic [DEF_NUM_CS-1:0] DEF_REGION_IO = 4'b1100;
  localparam logic [DEF_NUM_CS*DEF_WAIT_W-1:0] DEF_REGION_WAIT =
    {4'd3, 4'd1, 4'd2, 4'd0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    XFER = 2'd3
  } state_t;

  typedef struct packed {
    logic [REGION_FIELD_W-1:0]      base;
    logic [REGION_FIELD_W-1:0]      mask;
    logic                           io;
    logic [REGION_WAIT_FIELD_W-1:0] wait_states;
  } region_t;

  // RD and WR low together count as one strobe.
  function automatic logic strobe_active(input logic rd, input logic wr);
    return !rd || !wr;
  endfunction

endpackage

// File: rtl/bus_ctrl_if.sv
// CPU-side bus bundle for bus_ctrl_unit; extra error ports exist only
// when UNMAPPED_ERR_EN is defined.
interface bus_ctrl_if
  import bus_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CS = DEF_NUM_CS
);
  logic                     ALE;
  logic [DATA_W-1:0]        AD;
  logic [ADDR_W-DATA_W-1:0] A;
  logic                     IOM;
  logic                     RD;
  logic                     WR;
  logic                     DTR;
  logic                     DEN;
  logic [ADDR_W-1:0]        ADDRESS;
  logic [NUM_CS-1:0]        CS;
  logic                     READY;
  logic                     XCVR_TX;
  logic                     XCVR_RX;
  logic                     BUSY;
`ifdef UNMAPPED_ERR_EN
  logic                     BUS_ERR;
  logic [ADDR_W-1:0]        ERR_ADDR;

  modport master (
    output ALE, AD, A, IOM, RD, WR, DTR, DEN,
    input  ADDRESS, CS, READY, XCVR_TX, XCVR_RX, BUSY, BUS_ERR, ERR_ADDR
  );
  modport slave (
    input  ALE, AD, A, IOM, RD, WR, DTR, DEN,
    output ADDRESS, CS, READY, XCVR_TX, XCVR_RX, BUSY, BUS_ERR, ERR_ADDR
  );
`else
  modport master (
    output ALE, AD, A, IOM, RD, WR, DTR, DEN,
    input  ADDRESS, CS, READY, XCVR_TX, XCVR_RX, BUSY
  );
  modport slave (
    input  ALE, AD, A, IOM, RD, WR, DTR, DEN,
    output ADDRESS, CS, READY, XCVR_TX, XCVR_RX, BUSY
  );
`endif
endinterface

// File: rtl/bus_region_decode.sv
// Combinational region match and lowest-index priority select, returning the
// one-hot chip select and the wait-state count of the winning region.
module bus_region_decode
  import bus_ctrl_pkg::*;
#(
  parameter int                         ADDR_W      = DEF_ADDR_W,
  parameter int                         NUM_CS      = DEF_NUM_CS,
  parameter int                         WAIT_W      = DEF_WAIT_W,
  parameter logic [NUM_CS*ADDR_W-1:0]   REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_CS*ADDR_W-1:0]   REGION_MASK = DEF_REGION_MASK,
  parameter logic [NUM_CS-1:0]          REGION_IO   = DEF_REGION_IO,
  parameter logic [NUM_CS*WAIT_W-1:0]   REGION_WAIT = DEF_REGION_WAIT
) (
  input  logic [ADDR_W-1:0] address,
  input  logic              iom,
  output logic [NUM_CS-1:0] cs,
  output logic [WAIT_W-1:0] wait_states
);

  logic [NUM_CS-1:0] hit;
  logic [WAIT_W-1:0] region_wait [NUM_CS];

  for (genvar i = 0; i < NUM_CS; i++) begin : g_region
    localparam region_t R = '{
      base:        REGION_FIELD_W'(REGION_BASE[i*ADDR_W +: ADDR_W]),
      mask:        REGION_FIELD_W'(REGION_MASK[i*ADDR_W +: ADDR_W]),
      io:          REGION_IO[i],
      wait_states: REGION_WAIT_FIELD_W'(REGION_WAIT[i*WAIT_W +: WAIT_W])
    };
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(R.mask);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(R.base & R.mask);

    assign hit[i]         = (iom == R.io) && ((address & MASK) == BASE);
    assign region_wait[i] = WAIT_W'(R.wait_states);
  end

  // NOTE: every output gets a default before the loop, so no latch is inferred.
  always_comb begin
    logic found;
    found       = 1'b0;
    cs          = '0;
    wait_states = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (hit[i] && !found) begin
        found          = 1'b1;
        cs[i]          = 1'b1;
        wait_states    = region_wait[i];
      end
    end
  end

endmodule

// File: rtl/bus_ctrl_unit.sv
// Bus control unit: latches the multiplexed address, decodes chip selects and
// inserts per-region wait states. Optional macro: UNMAPPED_ERR_EN.
module bus_ctrl_unit
  import bus_ctrl_pkg::*;
#(
  parameter int                         ADDR_W      = DEF_ADDR_W,
  parameter int                         DATA_W      = DEF_DATA_W,
  parameter int                         NUM_CS      = DEF_NUM_CS,
  parameter int                         WAIT_W      = DEF_WAIT_W,
  parameter logic [NUM_CS*ADDR_W-1:0]   REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_CS*ADDR_W-1:0]   REGION_MASK = DEF_REGION_MASK,
  parameter logic [NUM_CS-1:0]          REGION_IO   = DEF_REGION_IO,
  parameter logic [NUM_CS*WAIT_W-1:0]   REGION_WAIT = DEF_REGION_WAIT
) (
  input logic        CLK,
  input logic        RESET,
  bus_ctrl_if.slave  bus
);

  state_t            state;
  logic [ADDR_W-1:0] address;
  logic              iom_cap;
  logic [NUM_CS-1:0] cs;
  logic              ready;
  logic              busy;
  logic [WAIT_W-1:0] count;
  logic [NUM_CS-1:0] dec_cs;
  logic [WAIT_W-1:0] dec_wait;
  logic              strobe;
`ifdef UNMAPPED_ERR_EN
  logic              bus_err;
  logic [ADDR_W-1:0] err_addr;
`endif

  bus_region_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_CS      (NUM_CS),
    .WAIT_W      (WAIT_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .REGION_IO   (REGION_IO),
    .REGION_WAIT (REGION_WAIT)
  ) u_decode (
    .address     (address),
    .iom         (iom_cap),
    .cs          (dec_cs),
    .wait_states (dec_wait)
  );

  assign strobe = strobe_active(bus.RD, bus.WR);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below sees the values from before this edge.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= IDLE;
      address  <= '0;
      iom_cap  <= 1'b0;
      cs       <= '0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      count    <= '0;
`ifdef UNMAPPED_ERR_EN
      bus_err  <= 1'b0;
      err_addr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.ALE) begin
            address[DATA_W-1:0]      <= bus.AD;
            address[ADDR_W-1:DATA_W] <= bus.A;
            iom_cap                  <= bus.IOM;
            busy                     <= 1'b1;
            state                    <= ADDR;
          end
        end
        ADDR: begin
          if (bus.ALE) begin
            address[DATA_W-1:0]      <= bus.AD;
            address[ADDR_W-1:DATA_W] <= bus.A;
            iom_cap                  <= bus.IOM;
            cs                       <= '0;
          end else begin
            cs <= dec_cs;
            if (strobe) begin
              count <= dec_wait;
              if (dec_wait == '0) begin
                state <= XFER;
              end else begin
                ready <= 1'b0;
                state <= WAIT;
              end
`ifdef UNMAPPED_ERR_EN
              // The first unmapped access is the one worth keeping for debug.
              if (dec_cs == '0 && !bus_err) begin
                bus_err  <= 1'b1;
                err_addr <= address;
              end
`endif
            end
          end
        end
        WAIT: begin
          if (!strobe) begin
            ready <= 1'b1;
            cs    <= '0;
            busy  <= 1'b0;
            count <= '0;
            state <= IDLE;
          end else if (count <= WAIT_W'(1)) begin
            ready <= 1'b1;
            count <= '0;
            state <= XFER;
          end else begin
            count <= count - WAIT_W'(1);
          end
        end
        XFER: begin
          // A new ALE closes this cycle and starts the next one immediately.
          if (bus.ALE) begin
            address[DATA_W-1:0]      <= bus.AD;
            address[ADDR_W-1:DATA_W] <= bus.A;
            iom_cap                  <= bus.IOM;
            cs                       <= '0;
            state                    <= ADDR;
          end else if (!strobe) begin
            cs    <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ADDRESS = address;
  assign bus.CS      = cs;
  assign bus.READY   = ready;
  assign bus.BUSY    = busy;
  assign bus.XCVR_TX = bus.DTR & ~bus.DEN;
  assign bus.XCVR_RX = ~bus.DTR & ~bus.DEN;
`ifdef UNMAPPED_ERR_EN
  assign bus.BUS_ERR  = bus_err;
  assign bus.ERR_ADDR = err_addr;
`endif

endmodule

// File: tb/tb_bus_ctrl_unit.sv
// Self-checking bench for bus_ctrl_unit: vector table with scoreboard plus
// hand-written multi-cycle corner cases.
module tb_bus_ctrl_unit;
  import bus_ctrl_pkg::*;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;
  localparam int NUM_CS = 4;
  localparam int NV     = 10;

  typedef struct {
    logic [19:0] addr;
    logic        iom;
    logic        wr;
    logic [3:0]  cs;
    int          waits;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  vec_t vecs [NV];
  vec_t sb [$];

  always #5 clk = ~clk;

  bus_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CS(NUM_CS)) bus_if ();

  bus_ctrl_unit dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus_if)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ale(input logic [19:0] addr, input logic iom);
    bus_if.ALE = 1'b1;
    bus_if.AD  = addr[7:0];
    bus_if.A   = addr[19:8];
    bus_if.IOM = iom;
  endtask

  task automatic release_bus();
    bus_if.RD  = 1'b1;
    bus_if.WR  = 1'b1;
    bus_if.DEN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    vec_t e;
    int   low;

    vecs[0] = '{20'h12345, 1'b0, 1'b0, 4'b0001, 0};
    vecs[1] = '{20'h80010, 1'b0, 1'b1, 4'b0010, 2};
    vecs[2] = '{20'h0FF05, 1'b1, 1'b0, 4'b0100, 1};
    vecs[3] = '{20'h01C40, 1'b1, 1'b1, 4'b1000, 3};
    vecs[4] = '{20'h02000, 1'b1, 1'b0, 4'b0000, 0};
    vecs[5] = '{20'h0FF05, 1'b0, 1'b0, 4'b0001, 0};
    vecs[6] = '{20'h0FF0F, 1'b1, 1'b1, 4'b0100, 1};
    vecs[7] = '{20'h0FF10, 1'b1, 1'b0, 4'b0000, 0};
    vecs[8] = '{20'h01DFF, 1'b1, 1'b0, 4'b1000, 3};
    vecs[9] = '{20'hFFFFF, 1'b0, 1'b1, 4'b0010, 2};

    bus_if.ALE = 1'b0;
    bus_if.AD  = '0;
    bus_if.A   = '0;
    bus_if.IOM = 1'b0;
    bus_if.DTR = 1'b0;
    release_bus();

    tick();
    tick();
    check("reset ADDRESS", 32'(bus_if.ADDRESS), 32'h0);
    check("reset CS",      32'(bus_if.CS),      32'h0);
    check("reset READY",   32'(bus_if.READY),   32'h1);
    check("reset BUSY",    32'(bus_if.BUSY),    32'h0);
`ifdef UNMAPPED_ERR_EN
    check("reset BUS_ERR", 32'(bus_if.BUS_ERR), 32'h0);
`endif
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive_ale(v.addr, v.iom);
      sb.push_back(v);
      tick();
      check($sformatf("v%0d ADDRESS", i), 32'(bus_if.ADDRESS), 32'(v.addr));
      check($sformatf("v%0d BUSY start", i), 32'(bus_if.BUSY), 32'h1);
      check($sformatf("v%0d CS before decode", i), 32'(bus_if.CS), 32'h0);

      bus_if.ALE = 1'b0;
      bus_if.DTR = v.wr;
      bus_if.DEN = 1'b0;
      if (v.wr) bus_if.WR = 1'b0;
      else      bus_if.RD = 1'b0;
      tick();

      e = sb.pop_front();
      check($sformatf("v%0d CS", i), 32'(bus_if.CS), 32'(e.cs));
      check($sformatf("v%0d XCVR_TX", i), 32'(bus_if.XCVR_TX), 32'(e.wr));
      check($sformatf("v%0d XCVR_RX", i), 32'(bus_if.XCVR_RX), 32'(!e.wr));
      low = 0;
      for (int k = 0; k < 16 && bus_if.READY === 1'b0; k++) begin
        low++;
        tick();
      end
      check($sformatf("v%0d wait cycles", i), 32'(low), 32'(e.waits));
      check($sformatf("v%0d BUSY xfer", i), 32'(bus_if.BUSY), 32'h1);
      check($sformatf("v%0d CS xfer", i), 32'(bus_if.CS), 32'(e.cs));

      release_bus();
      tick();
      check($sformatf("v%0d BUSY end", i), 32'(bus_if.BUSY), 32'h0);
      check($sformatf("v%0d CS end", i), 32'(bus_if.CS), 32'h0);
      check($sformatf("v%0d READY end", i), 32'(bus_if.READY), 32'h1);
    end
    check("scoreboard empty", 32'(sb.size()), 32'h0);

`ifdef UNMAPPED_ERR_EN
    check("BUS_ERR sticky", 32'(bus_if.BUS_ERR), 32'h1);
    check("ERR_ADDR", 32'(bus_if.ERR_ADDR), 32'h02000);
`endif

    // ALE during WAIT is ignored; the cycle keeps its address and wait count.
    drive_ale(20'h01C40, 1'b1);
    tick();
    bus_if.ALE = 1'b0;
    bus_if.RD  = 1'b0;
    tick();
    check("walE READY low", 32'(bus_if.READY), 32'h0);
    drive_ale(20'h0FF05, 1'b1);
    tick();
    bus_if.ALE = 1'b0;
    check("walE ADDRESS held", 32'(bus_if.ADDRESS), 32'h01C40);
    check("walE READY still low", 32'(bus_if.READY), 32'h0);
    check("walE CS held", 32'(bus_if.CS), 32'h8);
    tick();
    check("walE READY third", 32'(bus_if.READY), 32'h0);
    tick();
    check("walE READY back", 32'(bus_if.READY), 32'h1);
    release_bus();
    tick();
    check("walE BUSY end", 32'(bus_if.BUSY), 32'h0);

    // ALE during XFER restarts in ADDR with the new address.
    drive_ale(20'h80010, 1'b0);
    tick();
    bus_if.ALE = 1'b0;
    bus_if.WR  = 1'b0;
    tick();
    tick();
    tick();
    check("xale READY xfer", 32'(bus_if.READY), 32'h1);
    drive_ale(20'h0FF05, 1'b1);
    tick();
    bus_if.ALE = 1'b0;
    check("xale ADDRESS new", 32'(bus_if.ADDRESS), 32'h0FF05);
    check("xale CS cleared", 32'(bus_if.CS), 32'h0);
    check("xale BUSY kept", 32'(bus_if.BUSY), 32'h1);
    tick();
    check("xale CS new", 32'(bus_if.CS), 32'h4);
    check("xale READY low", 32'(bus_if.READY), 32'h0);
    tick();
    check("xale READY back", 32'(bus_if.READY), 32'h1);
    release_bus();
    tick();
    check("xale BUSY end", 32'(bus_if.BUSY), 32'h0);

    // RD and WR low together act as a single strobe.
    drive_ale(20'h0FF05, 1'b1);
    tick();
    bus_if.ALE = 1'b0;
    bus_if.RD  = 1'b0;
    bus_if.WR  = 1'b0;
    tick();
    check("both CS", 32'(bus_if.CS), 32'h4);
    check("both READY low", 32'(bus_if.READY), 32'h0);
    tick();
    check("both READY back", 32'(bus_if.READY), 32'h1);
    release_bus();
    tick();
    check("both BUSY end", 32'(bus_if.BUSY), 32'h0);

    // Strobe released during WAIT aborts the cycle.
    drive_ale(20'h80010, 1'b0);
    tick();
    bus_if.ALE = 1'b0;
    bus_if.WR  = 1'b0;
    tick();
    check("abort READY low", 32'(bus_if.READY), 32'h0);
    release_bus();
    tick();
    check("abort READY", 32'(bus_if.READY), 32'h1);
    check("abort BUSY", 32'(bus_if.BUSY), 32'h0);
    check("abort CS", 32'(bus_if.CS), 32'h0);

    // Reset during the WAIT of region 3.
    drive_ale(20'h01C40, 1'b1);
    tick();
    bus_if.ALE = 1'b0;
    bus_if.RD  = 1'b0;
    tick();
    tick();
    check("mrst READY low", 32'(bus_if.READY), 32'h0);
    rst_n = 1'b0;
    tick();
    check("mrst READY", 32'(bus_if.READY), 32'h1);
    check("mrst CS", 32'(bus_if.CS), 32'h0);
    check("mrst BUSY", 32'(bus_if.BUSY), 32'h0);
    check("mrst ADDRESS", 32'(bus_if.ADDRESS), 32'h0);
    rst_n = 1'b1;
    release_bus();
    tick();
    check("mrst idle READY", 32'(bus_if.READY), 32'h1);

    // Transceiver enables follow DTR/DEN combinationally.
    bus_if.DTR = 1'b1; bus_if.DEN = 1'b0; #1;
    check("xcvr tx TX", 32'(bus_if.XCVR_TX), 32'h1);
    check("xcvr tx RX", 32'(bus_if.XCVR_RX), 32'h0);
    bus_if.DTR = 1'b0; bus_if.DEN = 1'b0; #1;
    check("xcvr rx TX", 32'(bus_if.XCVR_TX), 32'h0);
    check("xcvr rx RX", 32'(bus_if.XCVR_RX), 32'h1);
    bus_if.DTR = 1'b1; bus_if.DEN = 1'b1; #1;
    check("xcvr off1 TX", 32'(bus_if.XCVR_TX), 32'h0);
    check("xcvr off1 RX", 32'(bus_if.XCVR_RX), 32'h0);
    bus_if.DTR = 1'b0; #1;
    check("xcvr off0 TX", 32'(bus_if.XCVR_TX), 32'h0);
    check("xcvr off0 RX", 32'(bus_if.XCVR_RX), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
